// File: rtl/spi_cfg_sequencer.sv
// Walks a table of fixed-length SPI commands and drives the SPI master engine's
// host-side register interface (reset, byte load, send, wait, read-back capture).
module spi_cfg_sequencer #(
  parameter int unsigned NUM_CMDS       = 8,
  parameter int unsigned BYTES_PER_CMD  = 3,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic                                i_Start,
  input  logic                                i_Abort,
  input  logic [3:0]                          i_Num_Cmds,
  input  logic [NUM_CMDS*BYTES_PER_CMD*8-1:0] i_Cfg_Table,
  input  logic [NUM_CMDS-1:0]                 i_Rd_Mask,
  input  logic [7:0]                          i_SpiStatus,
  input  logic [7:0]                          i_RxBuffer,
  output logic [7:0]                          o_StatusReg,
  output logic [7:0]                          o_TxBuffer,
  output logic [7:0]                          o_Cmd_Lim,
  output logic                                o_Busy,
  output logic                                o_Done,
  output logic                                o_Error,
  output logic [3:0]                          o_Cmd_Idx,
  output logic [7:0]                          o_Rd_Data,
  output logic                                o_Rd_Valid
);

  localparam int unsigned TableW = NUM_CMDS * BYTES_PER_CMD * 8;
  localparam int unsigned IdxW   = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int unsigned NumW   = $clog2(NUM_CMDS + 1);
  localparam int unsigned ByteW  = (BYTES_PER_CMD > 1) ? $clog2(BYTES_PER_CMD) : 1;
  localparam int unsigned SetW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned OffW   = $clog2(TableW);

  localparam logic [7:0] FlagNone  = 8'h00;
  localparam logic [7:0] FlagReset = 8'h01;
  localparam logic [7:0] FlagData  = 8'h02;
  localparam logic [7:0] FlagRece  = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StLoad,
    StGap,
    StSend,
    StWait,
    StSettle,
    StAbort
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   cmd_idx_q;
  logic [NumW-1:0]   num_q;
  logic [ByteW-1:0]  byte_cnt_q;
  logic [SetW-1:0]   settle_q;
  logic [TmoW-1:0]   tmo_q;
  logic [7:0]        status_q;
  logic [7:0]        tx_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;

  logic [NumW-1:0]   num_clamped;
  logic [31:0]       byte_sel;
  logic [31:0]       byte_off;
  logic [7:0]        cur_byte;
  logic              is_read;
  logic              last_byte;
  logic              last_cmd;
  logic              settle_end;
  logic              tmo_end;

  always_comb begin
    num_clamped = (32'(i_Num_Cmds) > NUM_CMDS) ? NumW'(NUM_CMDS) : NumW'(i_Num_Cmds);

    // In GAP the byte being prepared is the one after the counter
    byte_sel = 32'(byte_cnt_q) + ((state_q == StGap) ? 32'd1 : 32'd0);
    if (byte_sel >= BYTES_PER_CMD) begin
      byte_sel = BYTES_PER_CMD - 1;
    end
    byte_off = (32'(cmd_idx_q) * BYTES_PER_CMD + (BYTES_PER_CMD - 1 - byte_sel)) * 8;
    cur_byte = i_Cfg_Table[OffW'(byte_off) +: 8];

    is_read    = i_Rd_Mask[cmd_idx_q];
    last_byte  = (32'(byte_cnt_q) == BYTES_PER_CMD - 1);
    last_cmd   = ((32'(cmd_idx_q) + 32'd1) == 32'(num_q));
    settle_end = (32'(settle_q) == SETTLE_CYCLES - 1);
    tmo_end    = (32'(tmo_q) == TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      cmd_idx_q  <= '0;
      num_q      <= '0;
      byte_cnt_q <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      status_q   <= FlagNone;
      tx_q       <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      if (i_Abort && (state_q != StIdle) && (state_q != StAbort)) begin
        state_q  <= StAbort;
        status_q <= FlagReset;
      end else begin
        unique case (state_q)
          StIdle: begin
            status_q <= FlagNone;
            if (i_Start) begin
              error_q    <= 1'b0;
              cmd_idx_q  <= '0;
              byte_cnt_q <= '0;
              num_q      <= num_clamped;
              if (num_clamped == '0) begin
                done_q <= 1'b1;
              end else begin
                busy_q   <= 1'b1;
                state_q  <= StRst;
                status_q <= FlagReset;
              end
            end
          end
          StRst: begin
            state_q  <= StLoad;
            status_q <= FlagData;
            tx_q     <= cur_byte;
          end
          StLoad: begin
            state_q  <= StGap;
            status_q <= FlagNone;
          end
          StGap: begin
            if (last_byte) begin
              state_q  <= StSend;
              status_q <= {4'b0000, 1'b1, is_read, 2'b00};
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= StLoad;
              status_q   <= FlagData;
              tx_q       <= cur_byte;
            end
          end
          StSend: begin
            tmo_q    <= '0;
            state_q  <= StWait;
            status_q <= is_read ? FlagRece : FlagNone;
          end
          StWait: begin
            if (i_SpiStatus[7]) begin
              if (is_read) begin
                rd_data_q  <= i_RxBuffer;
                rd_valid_q <= 1'b1;
              end
              settle_q <= '0;
              state_q  <= StSettle;
              status_q <= FlagNone;
            end else if (tmo_end) begin
              error_q  <= 1'b1;
              state_q  <= StAbort;
              status_q <= FlagReset;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          StSettle: begin
            status_q <= FlagNone;
            if (settle_end) begin
              if (last_cmd) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                cmd_idx_q  <= cmd_idx_q + 1'b1;
                byte_cnt_q <= '0;
                state_q    <= StRst;
                status_q   <= FlagReset;
              end
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          StAbort: begin
            status_q <= FlagNone;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
          default: begin
            status_q <= FlagNone;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_StatusReg = status_q;
  assign o_TxBuffer  = tx_q;
  assign o_Cmd_Lim   = 8'(BYTES_PER_CMD);
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;
  assign o_Cmd_Idx   = 4'(cmd_idx_q);
  assign o_Rd_Data   = rd_data_q;
  assign o_Rd_Valid  = rd_valid_q;

endmodule
